conv1x1_s2_channel_scheduler: RTL

CONV1X1_S2_CHANNEL_SCHEDULER -- requirements
Module: conv1x1_s2_channel_scheduler

---
 rtl/conv1x1_s2_channel_scheduler.sv | 129 ++++++++++++
 1 files changed

// File: rtl/conv1x1_s2_channel_scheduler.sv
// Sequences a 1x1 stride-2 convolution over every (filter, input channel) pair:
// fetch one weight, stream a full input plane, then wait for that plane's results.
module conv1x1_s2_channel_scheduler #(
  parameter int  IMG_HEIGHT = 299,
  parameter int  IMG_WIDHT  = 299,
  parameter int  IN_CH      = 3,
  parameter int  OUT_CH     = 32,
  localparam int WA   = ($clog2(IN_CH * OUT_CH) > 1) ? $clog2(IN_CH * OUT_CH) : 1,
  localparam int ICW  = (IN_CH > 1) ? $clog2(IN_CH) : 1,
  localparam int OCW  = (OUT_CH > 1) ? $clog2(OUT_CH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           Start,
  input  logic [31:0]    Src_Data,
  input  logic           Src_Valid,
  output logic           Src_Ready,
  output logic [WA-1:0]  Weight_Addr,
  input  logic [31:0]    Weight_Data,
  output logic           Conv_Rst,
  output logic [31:0]    Conv_Data_In,
  output logic [31:0]    Conv_Kernel,
  output logic           Conv_Valid_In,
  input  logic           Conv_Valid_Out,
  output logic           Acc_Clear,
  output logic           Acc_Last,
  output logic [ICW-1:0] In_Ch,
  output logic [OCW-1:0] Out_Ch,
  output logic           Busy,
  output logic           Done,
  output logic           Err
);

  localparam int NPIX = IMG_HEIGHT * IMG_WIDHT;
  localparam int OPIX = ((IMG_HEIGHT + 1) / 2) * ((IMG_WIDHT + 1) / 2);
  localparam int PW   = $clog2(NPIX + 1);
  localparam int OW   = $clog2(OPIX + 1);

  typedef enum logic [2:0] {IDLE, LOAD_W, LATCH_W, STREAM, DRAIN, NEXT, FIN} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pix_cnt;
  logic [OW-1:0] out_cnt;
  logic          accept, out_active, in_last, out_last, pix_last, out_full;

  assign accept     = Src_Valid & Src_Ready;
  assign out_active = (state == STREAM) || (state == DRAIN);
  assign in_last    = (In_Ch == ICW'(IN_CH - 1));
  assign out_last   = (Out_Ch == OCW'(OUT_CH - 1));
  assign pix_last   = (pix_cnt == PW'(NPIX - 1));
  assign out_full   = (out_cnt == OW'(OPIX));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = LOAD_W;
      LOAD_W:  state_nxt = LATCH_W;
      LATCH_W: state_nxt = STREAM;
      STREAM:  if (accept && pix_last) state_nxt = DRAIN;
      DRAIN:   if (out_full) state_nxt = NEXT;
      NEXT:    state_nxt = (in_last && out_last) ? FIN : LOAD_W;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Weight address is only driven while fetching so the ROM bus idles at zero.
  always_comb begin
    Src_Ready     = (state == STREAM);
    Conv_Valid_In = Src_Valid & (state == STREAM);
    Conv_Data_In  = Src_Data;
    Conv_Rst      = rst | (state == LOAD_W);
    Weight_Addr   = '0;
    if (state == LOAD_W)
      Weight_Addr = WA'(Out_Ch) * WA'(IN_CH) + WA'(In_Ch);
    Acc_Clear     = (state == LATCH_W) && (In_Ch == '0);
    Acc_Last      = Conv_Valid_Out & in_last & out_active;
    Busy          = (state != IDLE);
    Done          = (state == FIN);
  end

  // A result outside STREAM/DRAIN or beyond the plane's quota is an overflow;
  // a new Start clears the sticky flag and takes priority over a stray result.
  always_ff @(posedge clk) begin
    if (rst) begin
      In_Ch       <= '0;
      Out_Ch      <= '0;
      pix_cnt     <= '0;
      out_cnt     <= '0;
      Err         <= 1'b0;
      Conv_Kernel <= '0;
    end else begin
      if (Conv_Valid_Out) begin
        if (out_active && !out_full) out_cnt <= out_cnt + OW'(1);
        else                         Err     <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (Start) begin
            In_Ch   <= '0;
            Out_Ch  <= '0;
            pix_cnt <= '0;
            out_cnt <= '0;
            Err     <= 1'b0;
          end
        end
        LATCH_W: Conv_Kernel <= Weight_Data;
        STREAM:  if (accept) pix_cnt <= pix_cnt + PW'(1);
        NEXT: begin
          pix_cnt <= '0;
          out_cnt <= '0;
          if (in_last) begin
            In_Ch  <= '0;
            Out_Ch <= out_last ? '0 : Out_Ch + OCW'(1);
          end else begin
            In_Ch  <= In_Ch + ICW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
